// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU micro-sequencer: instruction classes, system
// sub-codes, ALU selects, FSM states and a field decoder for program words.
package alu_seq_pkg;

    localparam int DATA_W   = 8;
    localparam int INSTR_W  = 16;
    localparam int NUM_REGS = 4;

    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_LDI = 2'b01,
        CLS_BRZ = 2'b10,
        CLS_SYS = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        SYS_HALT = 2'b00,
        SYS_JMP  = 2'b01,
        SYS_IN   = 2'b10,
        SYS_OUT  = 2'b11
    } sys_e;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_SUB  = 2'b01,
        OP_SHL  = 2'b10,
        OP_AND  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_WAIT_OUT = 3'd4
    } state_e;

    // Every field view of a program word; which ones matter depends on cls.
    typedef struct packed {
        cls_e              cls;
        sys_e              sub;
        alu_op_e           op;
        logic [1:0]        ldi_dst;
        logic [1:0]        alu_dst;
        logic [1:0]        io_reg;
        logic [1:0]        src_a;
        logic [1:0]        src_b;
        logic [DATA_W-1:0] imm;
    } decoded_t;

    function automatic decoded_t decode(input logic [INSTR_W-1:0] word);
        decoded_t d;
        d.cls     = cls_e'(word[15:14]);
        d.sub     = sys_e'(word[13:12]);
        d.op      = alu_op_e'(word[13:12]);
        d.ldi_dst = word[13:12];
        d.alu_dst = word[11:10];
        d.io_reg  = word[11:10];
        d.src_a   = word[9:8];
        d.src_b   = word[7:6];
        d.imm     = word[7:0];
        return d;
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational 8-bit ALU; z is the condition bit the sequencer latches
// into its flag, and its meaning changes with the select.
module ALU
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           s,
    output logic [DATA_W-1:0] c,
    output logic              z
);

    always_comb begin
        c = '0;
        z = 1'b0;
        case (s)
            OP_PASS: begin
                c = a;
                z = (a > b);
            end
            OP_SUB: begin
                c = b - a;
                z = (a != b);
            end
            OP_SHL: begin
                c = {b[DATA_W-2:0], a[0]};
                z = (a <= b);
            end
            OP_AND: begin
                c = a & b;
                z = |(a & b);
            end
            default: begin
                c = '0;
                z = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer: fetches 16-bit words from a synchronous ROM and runs ALU,
// load-immediate, branch and byte-stream I/O instructions on four registers.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(1);

    state_e            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [PC_W-1:0]   pc;
    logic [1:0]        in_dst;

    decoded_t          dec;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pc_inc;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_c;
    logic              alu_z;

    assign dec       = decode(prog_data);
    assign target    = prog_data[PC_W-1:0];
    assign pc_inc    = pc + PC_STEP;
    assign prog_addr = pc;
    assign alu_a     = regs[dec.src_a];
    assign alu_b     = regs[dec.src_b];

    ALU u_alu (
        .a (alu_a),
        .b (alu_b),
        .s (dec.op),
        .c (alu_c),
        .z (alu_z)
    );

    // The ROM word read during FETCH is valid throughout EXEC, so every
    // instruction commits its result and next pc on the EXEC edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            flag      <= 1'b0;
            in_dst    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    state <= ST_EXEC;
                end

                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (dec.cls)
                        CLS_ALU: begin
                            regs[dec.alu_dst] <= alu_c;
                            flag              <= alu_z;
                            pc                <= pc_inc;
                        end
                        CLS_LDI: begin
                            regs[dec.ldi_dst] <= dec.imm;
                            pc                <= pc_inc;
                        end
                        CLS_BRZ: begin
                            pc <= flag ? target : pc_inc;
                        end
                        CLS_SYS: begin
                            case (dec.sub)
                                SYS_HALT: begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end
                                SYS_JMP: begin
                                    pc <= target;
                                end
                                SYS_IN: begin
                                    in_dst   <= dec.io_reg;
                                    in_ready <= 1'b1;
                                    state    <= ST_WAIT_IN;
                                end
                                SYS_OUT: begin
                                    out_data  <= regs[dec.io_reg];
                                    out_valid <= 1'b1;
                                    state     <= ST_WAIT_OUT;
                                end
                                default: begin
                                    state <= ST_IDLE;
                                end
                            endcase
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end

                ST_WAIT_IN: begin
                    if (in_valid) begin
                        regs[in_dst] <= in_data;
                        in_ready     <= 1'b0;
                        pc           <= pc_inc;
                        state        <= ST_FETCH;
                    end
                end

                // out_data was latched in EXEC and stays put until accepted.
                ST_WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= ST_FETCH;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: ALU table vectors plus hand-written
// sequences for loops, handshakes, reset abort and pc wrap.
module tb_alu_sequencer;

    localparam int PC_W = 6;
    localparam int NUM_VECS = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [PC_W-1:0] prog_addr;
    logic [15:0]     prog_data = 16'h0;
    logic [7:0]      in_data = 8'h0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            flag;

    logic [15:0]     rom [64];

    int              checks = 0;
    int              errors = 0;

    logic [7:0]      out_log [$];
    int              in_xfers = 0;
    int              done_count = 0;
    int              loop_entries = 0;
    logic [PC_W-1:0] watch_addr = 6'd63;
    logic [PC_W-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flag      (flag)
    );

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) prog_data <= rom[prog_addr];

    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) out_log.push_back(out_data);
            if (in_valid && in_ready) in_xfers <= in_xfers + 1;
            if (done) done_count <= done_count + 1;
            if (busy && prog_addr == watch_addr && prev_addr != watch_addr)
                loop_entries <= loop_entries + 1;
        end
        prev_addr <= prog_addr;
    end

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_c;
        logic       exp_z;
    } alu_vec_t;

    alu_vec_t vecs [NUM_VECS];

    function automatic logic [15:0] enc_ldi(input logic [1:0] dst, input logic [7:0] imm);
        return {2'b01, dst, 4'b0000, imm};
    endfunction
    function automatic logic [15:0] enc_alu(input logic [1:0] s, input logic [1:0] dst,
                                            input logic [1:0] a, input logic [1:0] b);
        return {2'b00, s, dst, a, b, 6'b000000};
    endfunction
    function automatic logic [15:0] enc_brz(input logic [5:0] t);
        return {2'b10, 8'h00, t};
    endfunction
    function automatic logic [15:0] enc_halt();
        return 16'hC000;
    endfunction
    function automatic logic [15:0] enc_jmp(input logic [5:0] t);
        return {2'b11, 2'b01, 6'b000000, t};
    endfunction
    function automatic logic [15:0] enc_in(input logic [1:0] d);
        return {2'b11, 2'b10, d, 10'h000};
    endfunction
    function automatic logic [15:0] enc_out(input logic [1:0] s);
        return {2'b11, 2'b11, s, 10'h000};
    endfunction

    function automatic logic [7:0] out_at(input int idx);
        if (idx < out_log.size()) return out_log[idx];
        return 8'hxx;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'hC000;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses start so that it is sampled on the next rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts rising edges until done is seen, then steps one more cycle.
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", limit);
        cycles = -1;
    endtask

    // which: 0 waits for in_ready, 1 waits for out_valid.
    task automatic wait_signal(input int which, input int limit);
        int n = 0;
        while (!((which == 0) ? in_ready : out_valid)) begin
            if (n == limit) begin
                checks++;
                errors++;
                $display("[TB] FAIL wait_timeout: got signal %0d low, expected high", which);
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic load_sub_program();
        clear_rom();
        rom[0] = enc_ldi(2'd0, 8'd5);
        rom[1] = enc_ldi(2'd1, 8'd9);
        rom[2] = enc_alu(2'd1, 2'd2, 2'd0, 2'd1);
        rom[3] = enc_out(2'd2);
        rom[4] = enc_halt();
    endtask

    initial begin
        int cycles;
        int base;
        int dbase;
        int xbase;
        int lbase;

        vecs[0] = '{2'd1, 8'h05, 8'h09, 8'h04, 1'b1};
        vecs[1] = '{2'd1, 8'h09, 8'h05, 8'hFC, 1'b1};
        vecs[2] = '{2'd1, 8'h07, 8'h07, 8'h00, 1'b0};
        vecs[3] = '{2'd0, 8'h80, 8'h7F, 8'h80, 1'b1};
        vecs[4] = '{2'd0, 8'h10, 8'h10, 8'h10, 1'b0};
        vecs[5] = '{2'd2, 8'h01, 8'hC3, 8'h87, 1'b1};
        vecs[6] = '{2'd2, 8'hFE, 8'h05, 8'h0A, 1'b0};
        vecs[7] = '{2'd3, 8'hF0, 8'h0F, 8'h00, 1'b0};
        vecs[8] = '{2'd3, 8'hFF, 8'h81, 8'h81, 1'b1};
        vecs[9] = '{2'd2, 8'h33, 8'h33, 8'h67, 1'b1};

        clear_rom();
        apply_reset();
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_prog_addr", prog_addr, 6'd0);
        checkOutput("rst_flag", flag, 1'b0);

        // ALU table: LDI R0,a; LDI R1,b; ALU op R2=f(R0,R1); OUT R2; HALT
        out_ready = 1'b1;
        for (int i = 0; i < NUM_VECS; i++) begin
            clear_rom();
            rom[0] = enc_ldi(2'd0, vecs[i].a);
            rom[1] = enc_ldi(2'd1, vecs[i].b);
            rom[2] = enc_alu(vecs[i].op, 2'd2, 2'd0, 2'd1);
            rom[3] = enc_out(2'd2);
            rom[4] = enc_halt();
            base = out_log.size();
            applyStimulus();
            wait_done(100, cycles);
            checkOutput($sformatf("vec%0d_out", i), out_at(base), vecs[i].exp_c);
            checkOutput($sformatf("vec%0d_flag", i), flag, vecs[i].exp_z);
        end

        // Subtract-then-output with done latency
        load_sub_program();
        base = out_log.size();
        dbase = done_count;
        applyStimulus();
        wait_done(100, cycles);
        checkOutput("sub_latency", cycles, 11);
        checkOutput("sub_done_low_after", done, 1'b0);
        checkOutput("sub_done_count", done_count - dbase, 1);
        checkOutput("sub_out_count", out_log.size() - base, 1);
        checkOutput("sub_out_data", out_at(base), 8'h04);
        checkOutput("sub_flag", flag, 1'b1);
        checkOutput("sub_busy_idle", busy, 1'b0);

        // Same program with start re-pulsed mid-run
        base = out_log.size();
        dbase = done_count;
        applyStimulus();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midrun_busy", busy, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, cycles);
        checkOutput("midrun_latency", cycles + 5, 11);
        checkOutput("midrun_done_count", done_count - dbase, 1);
        checkOutput("midrun_out_count", out_log.size() - base, 1);

        // Countdown loop with dst == source
        clear_rom();
        rom[0] = enc_ldi(2'd0, 8'd1);
        rom[1] = enc_ldi(2'd1, 8'd3);
        rom[2] = enc_alu(2'd1, 2'd1, 2'd0, 2'd1);
        rom[3] = enc_alu(2'd1, 2'd3, 2'd0, 2'd1);
        rom[4] = enc_brz(6'd2);
        rom[5] = enc_out(2'd1);
        rom[6] = enc_halt();
        watch_addr = 6'd2;
        base = out_log.size();
        lbase = loop_entries;
        applyStimulus();
        wait_done(200, cycles);
        checkOutput("loop_r1", out_at(base), 8'h01);
        checkOutput("loop_body_runs", loop_entries - lbase, 2);
        checkOutput("loop_flag", flag, 1'b0);
        watch_addr = 6'd63;

        // IN handshake with three idle cycles, then echo via OUT
        clear_rom();
        rom[0] = enc_in(2'd2);
        rom[1] = enc_out(2'd2);
        rom[2] = enc_halt();
        base = out_log.size();
        xbase = in_xfers;
        applyStimulus();
        wait_signal(0, 20);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("in_ready_wait%0d", k), in_ready, 1'b1);
            checkOutput($sformatf("in_pc_wait%0d", k), prog_addr, 6'd0);
            @(posedge clk);
            #1;
        end
        in_data = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 8'h00;
        checkOutput("in_ready_dropped", in_ready, 1'b0);
        wait_done(100, cycles);
        checkOutput("in_xfer_count", in_xfers - xbase, 1);
        checkOutput("in_echo", out_at(base), 8'hA5);

        // OUT backpressure for five cycles
        clear_rom();
        rom[0] = enc_ldi(2'd3, 8'h3C);
        rom[1] = enc_out(2'd3);
        rom[2] = enc_halt();
        out_ready = 1'b0;
        base = out_log.size();
        applyStimulus();
        wait_signal(1, 20);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_valid%0d", k), out_valid, 1'b1);
            checkOutput($sformatf("bp_data%0d", k), out_data, 8'h3C);
            checkOutput($sformatf("bp_pc%0d", k), prog_addr, 6'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_valid_after", out_valid, 1'b0);
        checkOutput("bp_pc_after", prog_addr, 6'd2);
        wait_done(100, cycles);
        checkOutput("bp_out_count", out_log.size() - base, 1);
        checkOutput("bp_out_data", out_at(base), 8'h3C);

        // AND gives zero flag so BRZ falls through
        clear_rom();
        rom[0] = enc_ldi(2'd0, 8'hF0);
        rom[1] = enc_ldi(2'd1, 8'h0F);
        rom[2] = enc_alu(2'd3, 2'd2, 2'd0, 2'd1);
        rom[3] = enc_brz(6'd6);
        rom[4] = enc_out(2'd2);
        rom[5] = enc_halt();
        rom[6] = enc_ldi(2'd3, 8'hEE);
        rom[7] = enc_out(2'd3);
        rom[8] = enc_halt();
        base = out_log.size();
        applyStimulus();
        wait_done(100, cycles);
        checkOutput("and_out_count", out_log.size() - base, 1);
        checkOutput("and_result", out_at(base), 8'h00);
        checkOutput("and_flag", flag, 1'b0);

        // Reset asserted while waiting in WAIT_OUT
        clear_rom();
        rom[0] = enc_ldi(2'd0, 8'h11);
        rom[1] = enc_ldi(2'd1, 8'h22);
        rom[2] = enc_ldi(2'd2, 8'h33);
        rom[3] = enc_ldi(2'd3, 8'h44);
        rom[4] = enc_alu(2'd1, 2'd0, 2'd0, 2'd1);
        rom[5] = enc_out(2'd0);
        rom[6] = enc_halt();
        out_ready = 1'b0;
        applyStimulus();
        wait_signal(1, 40);
        checkOutput("pre_rst_out_data", out_data, 8'h11);
        checkOutput("pre_rst_flag", flag, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_out_data", out_data, 8'h00);
        checkOutput("abort_prog_addr", prog_addr, 6'd0);
        checkOutput("abort_flag", flag, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_rom();
        rom[0] = enc_out(2'd0);
        rom[1] = enc_out(2'd1);
        rom[2] = enc_out(2'd2);
        rom[3] = enc_out(2'd3);
        rom[4] = enc_halt();
        out_ready = 1'b1;
        base = out_log.size();
        applyStimulus();
        wait_done(100, cycles);
        checkOutput("post_rst_out_count", out_log.size() - base, 4);
        for (int r = 0; r < 4; r++) begin
            checkOutput($sformatf("post_rst_r%0d", r), out_at(base + r), 8'h00);
        end

        // JMP 63 then a non-branch at 63 wraps the fetch to address 0
        apply_reset();
        clear_rom();
        rom[0] = enc_out(2'd3);
        rom[1] = enc_alu(2'd0, 2'd0, 2'd3, 2'd2);
        rom[2] = enc_brz(6'd4);
        rom[3] = enc_jmp(6'd63);
        rom[4] = enc_halt();
        rom[63] = enc_ldi(2'd3, 8'h77);
        base = out_log.size();
        applyStimulus();
        wait_done(200, cycles);
        checkOutput("wrap_out_count", out_log.size() - base, 2);
        checkOutput("wrap_first", out_at(base), 8'h00);
        checkOutput("wrap_second", out_at(base + 1), 8'h77);
        checkOutput("wrap_flag", flag, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Micro-sequencer that drives the team's 8-bit `ALU` from a 64-word external program ROM. It holds four 8-bit working registers and a latched flag, and executes ALU, load-immediate, branch, and byte-stream I/O instructions. Valid/ready ports connect it to the I2C byte path. Software loads a program and pulses `start`. The block runs the program until HALT, then pulses `done`.

## Interface
- `PC_W`, default 6: program counter width; program depth is 2^PC_W words.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin execution at address 0; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when HALT executes.
- `prog_addr` out PC_W: ROM address, equal to `pc`.
- `prog_data` in 16: ROM word, with synchronous read latency of 1 cycle.
- `in_data` in 8: input byte.
- `in_valid` in 1: input byte is valid.
- `in_ready` out 1: sequencer accepts an input byte (high only in WAIT_IN).
- `out_data` out 8: output byte.
- `out_valid` out 1: output byte is valid.
- `out_ready` in 1: consumer accepts the output byte.
- `flag` out 1: latched ALU Z flag.

## Operation
- State: `R0`–`R3` (8-bit each), `pc` (PC_W bits), `flag` (1 bit), FSM.
- Instruction encoding, by `prog_data[15:14]`:
  - 00 ALU: `S=[13:12]`, `dst=[11:10]`, `srcA=[9:8]`, `srcB=[7:6]`. Drives ALU `A=R[srcA]`, `B=R[srcB]`. Writes `R[dst]=C` and `flag=Z`.
  - 01 LDI: `dst=[13:12]`, `imm=[7:0]`. Writes `R[dst]=imm`. Flag unchanged.
  - 10 BRZ: `target=[PC_W-1:0]`. If `flag`=1 then `pc=target`, else `pc+1`.
  - 11 SYS, with `sub=[13:12]`:
    - 00 HALT.
    - 01 JMP to `target`.
    - 10 IN to `dst=[11:10]`.
    - 11 OUT from `src=[11:10]`.
- ALU semantics, with flag = Z:
  - S0: `C=A`, `Z=A>B`.
  - S1: `C=B-A` mod 256, `Z=A!=B`.
  - S2: `C={B[6:0],A[0]}`, `Z=A<=B`.
  - S3: `C=A&B`, `Z=|(A&B)`.
- FSM states: IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT.
  - IDLE: on `start`, `pc<=0`, go to FETCH. Registers and flag are retained across runs.
  - FETCH: `prog_addr=pc`. Go to EXEC next cycle.
  - EXEC: decode `prog_data`. Commit result and next `pc` at the end of the cycle.
    - ALU/LDI/BRZ/JMP: go to FETCH.
    - IN: go to WAIT_IN.
    - OUT: latch `out_data=R[src]`, go to WAIT_OUT.
    - HALT: `done=1`, go to IDLE, `pc` unchanged.
  - WAIT_IN: `in_ready=1`. On `in_valid`, write `R[dst]=in_data`, `pc+1`, go to FETCH.
  - WAIT_OUT: `out_valid=1` with `out_data` stable. On `out_ready`, `pc+1`, go to FETCH.
- `pc+1` wraps from 2^PC_W−1 to 0.
- When `dst` equals a source register, the old value is read and the new value is written.
- `start` while busy is ignored.

## Timing
- Reset values: all registers, `pc`, and `flag` are 0. FSM is IDLE. `busy`, `done`, `in_ready`, `out_valid`, and `out_data` are 0. `prog_addr` is 0.
- Reset is asynchronous and aborts any state, including mid-handshake. No transfer completes on a reset cycle.
- Latency:
  - `start` sampled at cycle 0: FETCH in cycle 1, first EXEC in cycle 2.
  - Non-I/O instructions take 2 cycles.
  - IN/OUT take 2 cycles plus wait cycles. A transfer completing on the first WAIT cycle gives a 3-cycle instruction.
- Handshake: a transfer occurs on the cycle with valid&&ready both high.
  - `out_valid` does not drop before the transfer.
  - `in_ready` drops the cycle after the transfer.
- Register results are visible to the next instruction's EXEC. There is no hazard.

## Structure
- Shared package `alu_seq_pkg` holds:
  - class codes (`CLS_ALU`, `CLS_LDI`, `CLS_BRZ`, `CLS_SYS`),
  - sub-codes (`SYS_HALT`, `SYS_JMP`, `SYS_IN`, `SYS_OUT`),
  - ALU op codes (`OP_PASS`, `OP_SUB`, `OP_SHL`, `OP_AND`),
  - the FSM state enum.
- Single sub-module: one instance of the existing combinational `ALU`, with its select tied to `S`.

## Test plan
- ALU subtract then output:
  - Program: LDI R0,5; LDI R1,9; ALU S1 dst=R2 A=R0 B=R1; OUT R2; HALT.
  - Required: `out_data`=4 with `out_valid`, `flag`=1, `done` pulses once.
  - With `out_ready` tied high, `done` pulses 11 cycles after `start`.
- Countdown loop:
  - Program: LDI R0,1; LDI R1,3; loop: ALU S1 R1=R1-R0; ALU S1 R3=R1-R0 (flag=R0!=R1); BRZ loop; HALT.
  - Required: at HALT, R1=1 and the loop body ran 2 times.
- IN handshake: hold `in_valid` low for 3 cycles, then present 0xA5.
  - Required: `in_ready` stays high throughout the wait and captures exactly once.
  - A following OUT emits 0xA5.
- OUT backpressure: hold `out_ready` low for 5 cycles.
  - Required: `out_valid` stays high and `out_data` is stable for all 5 cycles.
  - `pc` advances only after the transfer.
- AND zero flag: R0=0xF0, R1=0x0F, ALU S3.
  - Required: result 0x00 and `flag`=0, so a following BRZ is not taken.
- Control boundaries:
  - `start` pulsed mid-run is ignored.
  - `rst_n` asserted in WAIT_OUT immediately gives `out_valid`=0, IDLE, and all registers 0.
  - JMP 63 followed by a non-branch instruction at 63 wraps the fetch to address 0.
